// File: rtl/alu_sequencer_if.sv
// Instruction issue and result response handshakes between
// an instruction source and the ALU sequencer.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_rd;

    modport master (
        output instr_valid, instr_op, instr_rd,
        output instr_rs1, instr_rs2, rsp_ready,
        input  instr_ready, rsp_valid, rsp_data, rsp_rd
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd,
        input  instr_rs1, instr_rs2, rsp_ready,
        output instr_ready, rsp_valid, rsp_data, rsp_rd
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/writeback controller around an external 16-bit ALU,
// with an 8x16 register file (r0 hardwired to zero).
module alu_sequencer (
    input  logic                clk,
    input  logic                rst,
    alu_sequencer_if.slave      bus,
    input  logic                ld_en,
    input  logic [2:0]          ld_addr,
    input  logic [15:0]         ld_data,
    output logic [15:0]         alu_a,
    output logic [15:0]         alu_b,
    output logic [2:0]          alu_sel,
    input  logic [15:0]         alu_out,
    input  logic [2:0]          dbg_addr,
    output logic [15:0]         dbg_data
);
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rsp_data_q;
    logic [2:0]        rsp_rd_q;
    logic              accept;

    assign accept = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.rsp_valid   = 1'b0;
        case (state)
            IDLE: bus.instr_ready = !ld_en;
            RESP: bus.rsp_valid   = 1'b1;
            default: ;
        endcase
    end

    // r0 is never written, so its storage stays at its reset zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en && ld_addr != 3'd0)
                        regs[ld_addr] <= ld_data;
                    if (accept) begin
                        alu_a    <= regs[bus.instr_rs1];
                        alu_b    <= regs[bus.instr_rs2];
                        alu_sel  <= bus.instr_op;
                        rsp_rd_q <= bus.instr_rd;
                    end
                end
                EXEC: begin
                    rsp_data_q <= alu_out;
                    if (rsp_rd_q != 3'd0)
                        regs[rsp_rd_q] <= alu_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_rd   = rsp_rd_q;
    assign dbg_data     = regs[dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a
// behavioural 16-bit ALU attached to its operand outputs.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Op 111 is an unsigned a > b compare.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'b000: alu_out = alu_a + alu_b;
            3'b001: alu_out = alu_a - alu_b;
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            3'b101: alu_out = alu_a << alu_b[3:0];
            3'b110: alu_out = alu_a >> alu_b[3:0];
            3'b111: alu_out = {15'd0, alu_a > alu_b};
            default: alu_out = '0;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic dbg_chk(input string name, input logic [2:0] a,
                           input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    // Returns one tick after the accept edge, i.e. during EXEC.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !bus.instr_ready; i++) tick();
        chk("accept_ready", bus.instr_ready, 1);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // From EXEC: check response, complete the handshake.
    task automatic respond(input string name, input logic [2:0] rd,
                           input logic [15:0] exp);
        tick();
        chk({name, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({name, "_rsp_data"}, bus.rsp_data, exp);
        chk({name, "_rsp_rd"}, bus.rsp_rd, rd);
        dbg_chk({name, "_dbg_wb"}, rd, (rd == 0) ? 16'h0 : exp);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        chk({name, "_rsp_drop"}, bus.rsp_valid, 0);
        chk({name, "_ready_back"}, bus.instr_ready, 1);
    endtask

    initial begin
        logic [15:0] hold_data;
        logic [2:0]  hold_rd;

        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.rsp_ready   = 1'b0;

        // r1 = 5, r2 = 3 when the table runs
        vecs[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 16'h0008};
        vecs[1] = '{3'd1, 3'd4, 3'd1, 3'd2, 16'h0002};
        vecs[2] = '{3'd2, 3'd5, 3'd1, 3'd2, 16'h0001};
        vecs[3] = '{3'd3, 3'd6, 3'd1, 3'd2, 16'h0007};
        vecs[4] = '{3'd4, 3'd7, 3'd1, 3'd2, 16'h0006};
        vecs[5] = '{3'd1, 3'd7, 3'd2, 3'd1, 16'hFFFE};
        vecs[6] = '{3'd0, 3'd0, 3'd1, 3'd2, 16'h0008};
        vecs[7] = '{3'd0, 3'd3, 3'd3, 3'd3, 16'h0010};

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_instr_ready", bus.instr_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_alu_a", alu_a, 0);

        // Reset pulse mid-idle wipes loaded state
        load(3'd4, 16'hAAAA);
        load(3'd7, 16'h5555);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("pulse_instr_ready", bus.instr_ready, 1);
        chk("pulse_rsp_valid", bus.rsp_valid, 0);
        chk("pulse_alu_sel", alu_sel, 0);
        for (int i = 0; i < 8; i++)
            dbg_chk($sformatf("pulse_dbg_r%0d", i), i[2:0], 16'h0);

        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(3'd0, 3'd3, 3'd1, 3'd2);
        chk("add_alu_a", alu_a, 16'h0005);
        chk("add_alu_b", alu_b, 16'h0003);
        chk("add_alu_sel", alu_sel, 0);
        respond("add", 3'd3, 16'h0008);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
            chk($sformatf("v%0d_sel", i), alu_sel, vecs[i].op);
            respond($sformatf("v%0d", i), vecs[i].rd, vecs[i].exp);
        end

        // Wrap then dependent compare
        load(3'd1, 16'h0000);
        load(3'd2, 16'h0001);
        issue(3'd1, 3'd4, 3'd1, 3'd2);
        respond("wrap_sub", 3'd4, 16'hFFFF);
        issue(3'd7, 3'd5, 3'd4, 3'd2);
        chk("dep_alu_a", alu_a, 16'hFFFF);
        respond("dep_cmp", 3'd5, 16'h0001);

        load(3'd0, 16'h1234);
        dbg_chk("r0_load", 3'd0, 16'h0000);

        // Backpressure: r6 holds 7 from the table
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(3'd0, 3'd0, 3'd1, 3'd2);
        tick();
        hold_data = bus.rsp_data;
        hold_rd   = bus.rsp_rd;
        chk("bp_data0", hold_data, 16'h0008);
        chk("bp_rd0", hold_rd, 0);
        ld_en   = 1'b1;
        ld_addr = 3'd6;
        ld_data = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), bus.rsp_valid, 1);
            chk($sformatf("bp_data%0d", i), bus.rsp_data, hold_data);
            chk($sformatf("bp_rd%0d", i), bus.rsp_rd, hold_rd);
            chk($sformatf("bp_ready%0d", i), bus.instr_ready, 0);
        end
        ld_en = 1'b0;
        dbg_chk("bp_ld_ignored", 3'd6, 16'h0007);
        dbg_chk("bp_r0", 3'd0, 16'h0000);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Load and instruction offered together
        ld_en   = 1'b1;
        ld_addr = 3'd1;
        ld_data = 16'h0010;
        bus.instr_op    = 3'd0;
        bus.instr_rd    = 3'd2;
        bus.instr_rs1   = 3'd1;
        bus.instr_rs2   = 3'd1;
        bus.instr_valid = 1'b1;
        #1;
        chk("prio_ready_low", bus.instr_ready, 0);
        tick();
        ld_en = 1'b0;
        #1;
        chk("prio_not_exec", bus.rsp_valid, 0);
        chk("prio_ready_next", bus.instr_ready, 1);
        dbg_chk("prio_loaded", 3'd1, 16'h0010);
        tick();
        bus.instr_valid = 1'b0;
        chk("prio_alu_a", alu_a, 16'h0010);
        respond("prio", 3'd2, 16'h0020);

        // Reset during EXEC of ADD r6
        issue(3'd0, 3'd6, 3'd1, 3'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        dbg_chk("rstmid_r6", 3'd6, 16'h0000);
        chk("rstmid_rsp_valid", bus.rsp_valid, 0);
        chk("rstmid_idle", bus.instr_ready, 1);
        tick();
        chk("rstmid_no_rsp", bus.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
